// File: rtl/mips_cpu_muldiv.sv
// mips_cpu_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Multiplies use a shift-add loop and divides use a restoring loop. Each takes
// 32 iterations followed by a sign-fixup cycle.
// Optional macro MIPS_CPU_MULDIV_FAST_MULT_EN switches multiplies to a
// single-cycle 64-bit multiplier. Divides are not affected by it.
module mips_cpu_muldiv (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam logic [2:0] OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI  = 3'd5, OP_MTLO = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FINISH} state_t;
  state_t state_q, state_d;

  logic [4:0]  cnt_q, cnt_d;
  // Mul: {partial product, multiplier}. Div: {remainder, dividend/quotient}.
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [31:0] araw_q, araw_d;   // raw dividend, returned in HI on divide-by-zero
  logic        is_div_q, is_div_d;
  logic        neg_p_q, neg_p_d; // negate product / quotient
  logic        neg_r_q, neg_r_d; // negate remainder
  logic        dbz_q, dbz_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_mul, op_div, op_sgn;
  logic [31:0] abs_a, abs_b;
  logic [32:0] msum, rsh, dtr;
  logic        qbit;

  assign op_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign op_div = (op == OP_DIV)  || (op == OP_DIVU);
  assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
  assign abs_a  = (op_sgn && a[31]) ? -a : a;
  assign abs_b  = (op_sgn && b[31]) ? -b : b;

  // One shift-add step and one restoring-divide step, from the current acc.
  assign msum = {1'b0, acc_q[63:32]} + {1'b0, opb_q};
  assign rsh  = acc_q[63:31];
  assign dtr  = rsh - {1'b0, opb_q};
  assign qbit = ~dtr[32];

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  logic [63:0] sprod, uprod;
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'b0, a} * {32'b0, b};
`endif

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0; acc_q <= '0; opb_q <= '0; araw_q <= '0;
      is_div_q <= 1'b0; neg_p_q <= 1'b0; neg_r_q <= 1'b0; dbz_q <= 1'b0;
      hi_q <= '0; lo_q <= '0; done_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d; acc_q <= acc_d; opb_q <= opb_d; araw_q <= araw_d;
      is_div_q <= is_div_d; neg_p_q <= neg_p_d; neg_r_q <= neg_r_d; dbz_q <= dbz_d;
      hi_q <= hi_d; lo_q <= lo_d; done_q <= done_d;
    end
  end

  // Next-state, iteration and HI/LO write logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    araw_d   = araw_q;
    is_div_d = is_div_q;
    neg_p_d  = neg_p_q;
    neg_r_d  = neg_r_q;
    dbz_d    = dbz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_div) begin
            state_d  = S_CALC;
            cnt_d    = 5'd31;
            acc_d    = {32'b0, abs_a};
            opb_d    = abs_b;
            araw_d   = a;
            is_div_d = 1'b1;
            neg_p_d  = op_sgn && (a[31] ^ b[31]);
            neg_r_d  = op_sgn && a[31];
            dbz_d    = (b == 32'b0);
          end else if (op_mul) begin
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
            {hi_d, lo_d} = (op == OP_MULT) ? sprod : uprod;
            done_d       = 1'b1;
`else
            state_d  = S_CALC;
            cnt_d    = 5'd31;
            acc_d    = {32'b0, abs_b};
            opb_d    = abs_a;
            araw_d   = a;
            is_div_d = 1'b0;
            neg_p_d  = op_sgn && (a[31] ^ b[31]);
            neg_r_d  = 1'b0;
            dbz_d    = 1'b0;
`endif
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      S_CALC: begin
        if (is_div_q) acc_d = {(qbit ? dtr[31:0] : rsh[31:0]), acc_q[30:0], qbit};
        else          acc_d = acc_q[0] ? {msum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (is_div_q) begin
          if (dbz_q) begin
            hi_d = araw_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = neg_p_q ? -acc_q[31:0]  : acc_q[31:0];
            hi_d = neg_r_q ? -acc_q[63:32] : acc_q[63:32];
          end
        end else begin
          {hi_d, lo_d} = neg_p_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: directed cases with literal results, then a
// random stream. A cycle-level reference model is compared on every cycle.
module tb_mips_cpu_muldiv;
  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  mips_cpu_muldiv dut (.clk(clk), .reset(reset), .start(start), .op(op),
                       .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Architectural results computed with plain arithmetic.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint p;
    logic [63:0] u;
    rh = 32'h0; rl = 32'h0;
    case (o)
      3'd1: begin p = longint'($signed(x)) * longint'($signed(y)); {rh, rl} = p; end
      3'd2: begin u = {32'b0, x} * {32'b0, y}; {rh, rl} = u; end
      3'd3, 3'd4: begin
        if (y == 0) begin rh = x; rl = 32'hFFFF_FFFF; end
        else if (o == 3'd3 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 0;
        end else if (o == 3'd3) begin
          rl = $signed(x) / $signed(y); rh = $signed(x) % $signed(y);
        end else begin
          rl = x / y; rh = x % y;
        end
      end
      default: ;
    endcase
  endfunction

  // Cycle-level model: remaining latency count plus pending result.
  int          m_rem = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  bit          m_done = 0;
  always @(posedge clk) begin
    if (reset) begin
      m_rem = 0; m_hi = 0; m_lo = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
      end else if (start) begin
        if (op == 3'd5) m_hi = a;
        else if (op == 3'd6) m_lo = a;
        else if (op >= 3'd1 && op <= 3'd4) begin
          ref_op(op, a, b, p_hi, p_lo);
          if (FAST && op <= 3'd2) begin m_hi = p_hi; m_lo = p_lo; m_done = 1; end
          else m_rem = 33;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, (m_rem > 0)});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 80) begin @(negedge clk); n++; end
    if (busy) chk("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue an op, check model vs literal, latency, busy length and DUT result.
  task automatic run(input string name, input logic [2:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] rh, rl;
    int n, nb, exp_lat;
    ref_op(o, x, y, rh, rl);
    chk({name, "_model_hi"}, rh, eh);
    chk({name, "_model_lo"}, rl, el);
    exp_lat = (FAST && o <= 3'd2) ? 1 : 34;
    issue(o, x, y);
    n = 1; nb = 0;
    while (!done && n < 80) begin
      if (busy) nb++;
      @(negedge clk); n++;
    end
    chk({name, "_latency"}, n, exp_lat);
    chk({name, "_busy_cycles"}, nb, exp_lat - 1);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dcnt;
    reset = 1'b1; start = 1'b0; op = 3'd0; a = 0; b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run("mult_neg",  3'd1, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run("mult_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1);
    run("div_neg",   3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu",      3'd4, 32'd7,         32'd2,        32'd1,         32'd3);
    run("div_zero",  3'd3, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
    run("div_ovf",   3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

    // MTHI during a DIVU is dropped.
    issue(3'd4, 32'd7, 32'd2);
    repeat (4) @(negedge clk);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    wait_idle();
    chk("mthi_busy_hi", hi, 32'd1);
    chk("mthi_busy_lo", lo, 32'd3);

    // MTLO in IDLE: visible next cycle, no done.
    issue(3'd6, 32'h1234_5678, 32'd0);
    chk("mtlo_lo", lo, 32'h1234_5678);
    chk("mtlo_done", {31'b0, done}, 32'd0);
    chk("mtlo_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a multiply.
    issue(3'd1, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    dcnt = 0;
    repeat (40) begin @(negedge clk); if (done) dcnt++; end
    chk("abort_no_done", dcnt, 32'd0);

    // Random stream, including requests while busy and back-to-back ops.
    repeat (3000) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = rnd_operand();
      b     = rnd_operand();
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
